regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- Parametrised register file that generalises the flat 32-input, 32-bit select mux into a clocked storage array.
- Two independent synchronous read ports and one write port.
- Configurable data width, address width and hardwired-zero register 0.
- Sits between the decode and execute stages of the CPU datapath.
- Read data is registered (1-cycle latency); bypass of a same-cycle write is optional.

Parameters:
- DATA_W, 32, width of each register and data port in bits.
- ADDR_W, 5, address width; the array has DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, when 1, entry 0 always reads 0 and writes to it are dropped; when 0, entry 0 is an ordinary register.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- re_a  input  1  read enable, port A.
- raddr_a  input  ADDR_W  read address, port A.
- rdata_a  output  DATA_W  registered read data, port A.
- re_b  input  1  read enable, port B.
- raddr_b  input  ADDR_W  read address, port B.
- rdata_b  output  DATA_W  registered read data, port B.
- rvalid_a  output  1  high the cycle after an accepted port-A read.
- rvalid_b  output  1  high the cycle after an accepted port-B read.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All DEPTH entries cleared to 0.
  - rdata_a and rdata_b = 0; rvalid_a and rvalid_b = 0.
  - Reset overrides we, re_a and re_b in the same cycle; no write is performed.
- Write:
  - At an edge with rst_n=1 and we=1, mem[waddr] <= wdata.
  - If ZERO_REG=1 and waddr=0, the write is discarded.
- Read, port A (port B identical and independent):
  - At an edge with re_a=1, rdata_a <= mem[raddr_a] and rvalid_a <= 1.
  - At an edge with re_a=0, rdata_a holds its previous value and rvalid_a <= 0.
  - Latency is exactly one cycle from the address edge to data.
- If ZERO_REG=1 and raddr=0, the registered read data is 0 regardless of array contents.
- Both ports may read the same address in the same cycle; both return the same value.
- Same-cycle write and read to the same address: see Optional Feature.
- Addresses are full-range; there is no out-of-range condition.
- The array is a storage array with no inferred reset on memory beyond the clear loop; the reset clear takes one cycle.
- Reset asserted mid-stream:
  - The next edge clears everything.
  - A read enabled in that cycle produces rvalid=0 and rdata=0.
- No X propagation is permitted: every output is defined from the first reset edge onward.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-first):
  - When we=1, re_x=1 and raddr_x==waddr in the same cycle, rdata_x <= wdata.
  - Exception: if ZERO_REG=1 and the address is 0, rdata_x <= 0.
- Undefined (read-first): rdata_x <= the old mem contents; the new value is visible from the following read onward.

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles with we=1, waddr=3, wdata=32'hDEAD_BEEF, then release. Read address 3 on port A -> rdata_a=0 and rvalid_a=1 one cycle after re_a.
- Fill and readback: write mem[i]=i*32'h0101_0101 for i=1..31. Read i on port A and 31-i on port B. -> Each port returns its value one cycle later; both rvalid flags are high.
- Zero register: with ZERO_REG=1, write waddr=0, wdata=32'hFFFF_FFFF, then read address 0 on both ports -> rdata_a=rdata_b=0. With ZERO_REG=0, the same sequence -> 32'hFFFF_FFFF on both.
- Collision: mem[5]=32'h1111_1111. In one cycle, we=1, waddr=5, wdata=32'h2222_2222, re_a=1, raddr_a=5. -> With REGFILE_BYPASS_EN, rdata_a=32'h2222_2222; without it, rdata_a=32'h1111_1111. The next read returns 32'h2222_2222 in both builds.
- Hold and valid: read address 7 (value 32'h7777_7777), then drive re_a=0 for 3 cycles while changing raddr_a. -> rdata_a stays 32'h7777_7777 and rvalid_a=0 for those cycles.
- Generic width: instantiate DATA_W=16, ADDR_W=3. Write 16'hA5A5 to entry 7, read it back -> 16'hA5A5. Writing waddr=0 is dropped (ZERO_REG=1).

Source files
------------

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised register file, two registered read ports, one write port.
// Read data arrives one cycle after the address edge; rvalid_x marks a fresh read.
// Optional macro REGFILE_BYPASS_EN selects write-first behaviour on a same-cycle
// write/read to one address; left undefined the array is read-first.
module regfile_2r1w #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_a,
  output logic              rvalid_b
);

  localparam int DEPTH    = 2 ** ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
  logic              rvalid_a_q, rvalid_a_d;
  logic              rvalid_b_q, rvalid_b_d;

  // Value a read port captures for a given address this cycle.
  function automatic logic [DATA_W-1:0] read_value(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data
  );
    logic [DATA_W-1:0] val;
    val = stored;
`ifdef REGFILE_BYPASS_EN
    // Write-first: a same-cycle write to this address is forwarded.
    if (wr_en && (wr_addr == addr)) val = wr_data;
`else
    // Read-first: the old contents are returned; the write lands at this edge.
    if (wr_en && (wr_addr == addr)) val = stored;
`endif
    // Hardwired zero wins over both storage and forwarding.
    if (HAS_ZERO && (addr == '0)) val = '0;
    return val;
  endfunction

  // Next state: array write, then both read ports independently.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    mem_d      = mem_q;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    rvalid_a_d = re_a;
    rvalid_b_d = re_b;

    if (we && !(HAS_ZERO && (waddr == '0))) mem_d[waddr] = wdata;

    if (re_a) rdata_a_d = read_value(raddr_a, mem_q[raddr_a], we, waddr, wdata);
    if (re_b) rdata_b_d = read_value(raddr_b, mem_q[raddr_b], we, waddr, wdata);
  end

  // State registers with synchronous clear of the whole array and read pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the array is cleared on reset because software expects every register
      // to read 0 after reset; this costs a reset path on every storage bit.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      // NOTE: non-blocking assignments in sequential blocks keep all flops
      // updating from the same pre-edge values.
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed, table-driven bench for regfile_2r1w.
// Three instances: default (32x32, zero reg), ZERO_REG=0, and a 16-bit x 8 variant.
module tb_regfile_2r1w;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] COLL_EXP = 32'h2222_2222;
`else
  localparam logic [31:0] COLL_EXP = 32'h1111_1111;
`endif

  // Main instance signals
  logic        we, re_a, re_b;
  logic [4:0]  waddr, raddr_a, raddr_b;
  logic [31:0] wdata, rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b;

  // ZERO_REG=0 instance signals
  logic        nz_we, nz_re_a, nz_re_b;
  logic [4:0]  nz_waddr, nz_raddr_a, nz_raddr_b;
  logic [31:0] nz_wdata, nz_rdata_a, nz_rdata_b;
  logic        nz_rvalid_a, nz_rvalid_b;

  // Small instance signals
  logic        sm_we, sm_re_a, sm_re_b;
  logic [2:0]  sm_waddr, sm_raddr_a, sm_raddr_b;
  logic [15:0] sm_wdata, sm_rdata_a, sm_rdata_b;
  logic        sm_rvalid_a, sm_rvalid_b;

  regfile_2r1w dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .rvalid_a(rvalid_a), .rvalid_b(rvalid_b)
  );

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .we(nz_we), .waddr(nz_waddr), .wdata(nz_wdata),
    .re_a(nz_re_a), .raddr_a(nz_raddr_a), .rdata_a(nz_rdata_a),
    .re_b(nz_re_b), .raddr_b(nz_raddr_b), .rdata_b(nz_rdata_b),
    .rvalid_a(nz_rvalid_a), .rvalid_b(nz_rvalid_b)
  );

  regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut_sm (
    .clk(clk), .rst_n(rst_n), .we(sm_we), .waddr(sm_waddr), .wdata(sm_wdata),
    .re_a(sm_re_a), .raddr_a(sm_raddr_a), .rdata_a(sm_rdata_a),
    .re_b(sm_re_b), .raddr_b(sm_raddr_b), .rdata_b(sm_rdata_b),
    .rvalid_a(sm_rvalid_a), .rvalid_b(sm_rvalid_b)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re_a;
    logic [4:0]  raddr_a;
    logic        re_b;
    logic [4:0]  raddr_b;
    logic        exp_rvalid_a;
    logic [31:0] exp_rdata_a;
    logic        exp_rvalid_b;
    logic [31:0] exp_rdata_b;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs and sampling both sit 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic ra, input logic [4:0] aa, input logic rb,
                              input logic [4:0] ab, input logic va, input logic [31:0] da,
                              input logic vb, input logic [31:0] db);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd;
    v.re_a = ra; v.raddr_a = aa; v.re_b = rb; v.raddr_b = ab;
    v.exp_rvalid_a = va; v.exp_rdata_a = da; v.exp_rvalid_b = vb; v.exp_rdata_b = db;
    return v;
  endfunction

  initial begin
    logic [31:0] va, vb;

    //           we wa   wdata          ra aa  rb ab  va da             vb db
    vecs[0]  = mk(1, 5,  32'h1111_1111, 0, 0,  0, 0,  0, 32'h1F1F_1F1F, 0, 32'h0000_0000);
    vecs[1]  = mk(1, 7,  32'h7777_7777, 0, 0,  0, 0,  0, 32'h1F1F_1F1F, 0, 32'h0000_0000);
    vecs[2]  = mk(1, 0,  32'hFFFF_FFFF, 0, 0,  0, 0,  0, 32'h1F1F_1F1F, 0, 32'h0000_0000);
    vecs[3]  = mk(0, 0,  32'h0,         1, 0,  1, 0,  1, 32'h0000_0000, 1, 32'h0000_0000);
    vecs[4]  = mk(1, 5,  32'h2222_2222, 1, 5,  1, 5,  1, COLL_EXP,      1, COLL_EXP);
    vecs[5]  = mk(0, 0,  32'h0,         1, 5,  0, 0,  1, 32'h2222_2222, 0, COLL_EXP);
    vecs[6]  = mk(0, 0,  32'h0,         1, 7,  1, 7,  1, 32'h7777_7777, 1, 32'h7777_7777);
    vecs[7]  = mk(0, 0,  32'h0,         0, 1,  0, 4,  0, 32'h7777_7777, 0, 32'h7777_7777);
    vecs[8]  = mk(0, 0,  32'h0,         0, 2,  0, 5,  0, 32'h7777_7777, 0, 32'h7777_7777);
    vecs[9]  = mk(0, 0,  32'h0,         0, 3,  0, 6,  0, 32'h7777_7777, 0, 32'h7777_7777);
    vecs[10] = mk(0, 0,  32'h0,         1, 1,  1, 1,  1, 32'h0101_0101, 1, 32'h0101_0101);
    vecs[11] = mk(1, 0,  32'h0000_ABCD, 1, 0,  0, 0,  1, 32'h0000_0000, 0, 32'h0101_0101);
    vecs[12] = mk(1, 31, 32'hCAFE_F00D, 0, 0,  0, 0,  0, 32'h0000_0000, 0, 32'h0101_0101);
    vecs[13] = mk(0, 0,  32'h0,         1, 31, 1, 30, 1, 32'hCAFE_F00D, 1, 32'h1E1E_1E1E);

    // Idle all inputs
    we = 0; waddr = 0; wdata = 0; re_a = 0; raddr_a = 0; re_b = 0; raddr_b = 0;
    nz_we = 0; nz_waddr = 0; nz_wdata = 0; nz_re_a = 0; nz_raddr_a = 0; nz_re_b = 0; nz_raddr_b = 0;
    sm_we = 0; sm_waddr = 0; sm_wdata = 0; sm_re_a = 0; sm_raddr_a = 0; sm_re_b = 0; sm_raddr_b = 0;

    // Reset for two cycles while a write and reads are requested: all ignored.
    rst_n = 0; we = 1; waddr = 3; wdata = 32'hDEAD_BEEF; re_a = 1; raddr_a = 3;
    re_b = 1; raddr_b = 3;
    tick();
    check("rst1 rdata_a", rdata_a, 32'h0);
    check("rst1 rvalid_a", {31'b0, rvalid_a}, 32'h0);
    check("rst1 rdata_b", rdata_b, 32'h0);
    check("rst1 rvalid_b", {31'b0, rvalid_b}, 32'h0);
    check("rst1 nz rdata_a", nz_rdata_a, 32'h0);
    check("rst1 sm rdata_a", {16'h0, sm_rdata_a}, 32'h0);
    tick();
    check("rst2 rvalid_a", {31'b0, rvalid_a}, 32'h0);
    rst_n = 1; we = 0; re_b = 0;
    tick();
    check("post-rst rdata_a[3]", rdata_a, 32'h0);
    check("post-rst rvalid_a", {31'b0, rvalid_a}, 32'h1);
    re_a = 0;

    // Fill entries 1..31 with i * 0x01010101.
    for (int i = 1; i < 32; i++) begin
      we = 1; waddr = 5'(i); wdata = 32'(i) * 32'h0101_0101;
      tick();
    end
    we = 0;

    // Read back: port A reads i, port B reads 31-i (entry 0 reads 0).
    for (int i = 1; i < 32; i++) begin
      re_a = 1; raddr_a = 5'(i); re_b = 1; raddr_b = 5'(31 - i);
      va = 32'(i) * 32'h0101_0101;
      vb = 32'(31 - i) * 32'h0101_0101;
      tick();
      check($sformatf("fill rdata_a[%0d]", i), rdata_a, va);
      check($sformatf("fill rdata_b[%0d]", 31 - i), rdata_b, vb);
      check($sformatf("fill rvalid_a %0d", i), {31'b0, rvalid_a}, 32'h1);
      check($sformatf("fill rvalid_b %0d", i), {31'b0, rvalid_b}, 32'h1);
    end

    // Table: zero register, collision, hold, same-address dual read.
    for (int i = 0; i < NVEC; i++) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      re_a = vecs[i].re_a; raddr_a = vecs[i].raddr_a;
      re_b = vecs[i].re_b; raddr_b = vecs[i].raddr_b;
      tick();
      check($sformatf("vec%0d rdata_a", i), rdata_a, vecs[i].exp_rdata_a);
      check($sformatf("vec%0d rvalid_a", i), {31'b0, rvalid_a}, {31'b0, vecs[i].exp_rvalid_a});
      check($sformatf("vec%0d rdata_b", i), rdata_b, vecs[i].exp_rdata_b);
      check($sformatf("vec%0d rvalid_b", i), {31'b0, rvalid_b}, {31'b0, vecs[i].exp_rvalid_b});
    end

    // Reset mid-stream with a write and both reads enabled.
    rst_n = 0; we = 1; waddr = 9; wdata = 32'h9999_9999;
    re_a = 1; raddr_a = 7; re_b = 1; raddr_b = 31;
    tick();
    check("midrst rdata_a", rdata_a, 32'h0);
    check("midrst rvalid_a", {31'b0, rvalid_a}, 32'h0);
    check("midrst rdata_b", rdata_b, 32'h0);
    check("midrst rvalid_b", {31'b0, rvalid_b}, 32'h0);
    rst_n = 1; we = 0; raddr_a = 7; raddr_b = 9;
    tick();
    check("midrst mem[7]", rdata_a, 32'h0);
    check("midrst mem[9]", rdata_b, 32'h0);
    check("midrst rvalid_a after", {31'b0, rvalid_a}, 32'h1);
    re_a = 0; re_b = 0;

    // ZERO_REG=0: entry 0 is ordinary storage.
    nz_we = 1; nz_waddr = 0; nz_wdata = 32'hFFFF_FFFF;
    tick();
    nz_we = 0; nz_re_a = 1; nz_raddr_a = 0; nz_re_b = 1; nz_raddr_b = 0;
    tick();
    check("nz rdata_a[0]", nz_rdata_a, 32'hFFFF_FFFF);
    check("nz rdata_b[0]", nz_rdata_b, 32'hFFFF_FFFF);
    nz_re_a = 0; nz_re_b = 0;

    // 16-bit x 8 instance: write 7, attempt write 0, read both back.
    sm_we = 1; sm_waddr = 7; sm_wdata = 16'hA5A5;
    tick();
    sm_waddr = 0; sm_wdata = 16'h1234;
    tick();
    sm_we = 0; sm_re_a = 1; sm_raddr_a = 7; sm_re_b = 1; sm_raddr_b = 0;
    tick();
    check("sm rdata_a[7]", {16'h0, sm_rdata_a}, 32'h0000_A5A5);
    check("sm rdata_b[0]", {16'h0, sm_rdata_b}, 32'h0);
    check("sm rvalid_a", {31'b0, sm_rvalid_a}, 32'h1);
    sm_re_a = 0; sm_re_b = 0;
    tick();
    check("sm rvalid_a drop", {31'b0, sm_rvalid_a}, 32'h0);
    check("sm rdata_a hold", {16'h0, sm_rdata_a}, 32'h0000_A5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
